// File: rtl/e_mdu.sv
// e_mdu: multi-cycle multiply/divide unit owning architectural HI/LO.
// Optional MADD/MADDU/MSUB/MSUBU support is enabled by defining E_MDU_MADD_EN.
module e_mdu #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_e;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MADD  = 4'd7,
        OP_MADDU = 4'd8,
        OP_MSUB  = 4'd9,
        OP_MSUBU = 4'd10
    } op_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         op_q, op_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;

    logic               is_mul;
    logic               is_div;
    logic               op_signed;
    logic [63:0]        a64;
    logic [63:0]        b64;
    logic [63:0]        prod;
    logic               a_neg;
    logic               b_neg;
    logic [31:0]        a_mag;
    logic [31:0]        b_mag;
    logic [31:0]        quo_mag;
    logic [31:0]        rem_mag;
    logic [31:0]        quo;
    logic [31:0]        rem;
    logic [31:0]        res_hi;
    logic [31:0]        res_lo;

    always_comb begin
        is_mul = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU)
`ifdef E_MDU_MADD_EN
              || (mdu_op == OP_MADD) || (mdu_op == OP_MADDU)
              || (mdu_op == OP_MSUB) || (mdu_op == OP_MSUBU)
`endif
              ;
        is_div = (mdu_op == OP_DIV) || (mdu_op == OP_DIVU);
    end

    // Operand sign handling is shared by the multiplier and the divider.
    always_comb begin
        op_signed = (op_q == OP_MULT) || (op_q == OP_DIV)
`ifdef E_MDU_MADD_EN
                 || (op_q == OP_MADD) || (op_q == OP_MSUB)
`endif
                 ;
        a64  = op_signed ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
        b64  = op_signed ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
        prod = a64 * b64;

        // Magnitude divide avoids the INT_MIN / -1 overflow corner of a native signed divide.
        a_neg   = op_signed && a_q[31];
        b_neg   = op_signed && b_q[31];
        a_mag   = a_neg ? (32'd0 - a_q) : a_q;
        b_mag   = b_neg ? (32'd0 - b_q) : b_q;
        quo_mag = a_mag / b_mag;
        rem_mag = a_mag % b_mag;
        quo     = (a_neg ^ b_neg) ? (32'd0 - quo_mag) : quo_mag;
        rem     = a_neg ? (32'd0 - rem_mag) : rem_mag;
    end

    always_comb begin
        res_hi = hi_q;
        res_lo = lo_q;
        case (op_q)
            OP_MULT, OP_MULTU: {res_hi, res_lo} = prod;
            OP_DIV, OP_DIVU: begin
                if (b_q != 32'd0) begin
                    res_hi = rem;
                    res_lo = quo;
                end
            end
`ifdef E_MDU_MADD_EN
            OP_MADD, OP_MADDU: {res_hi, res_lo} = {hi_q, lo_q} + prod;
            OP_MSUB, OP_MSUBU: {res_hi, res_lo} = {hi_q, lo_q} - prod;
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (is_mul || is_div) begin
                        state_d = S_RUN;
                        op_d    = mdu_op;
                        a_d     = rs_val;
                        b_d     = rt_val;
                        cnt_d   = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
                    end else if (mdu_op == OP_MTHI) begin
                        hi_d = rs_val;
                    end else if (mdu_op == OP_MTLO) begin
                        lo_d = rs_val;
                    end
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_IDLE;
                    hi_d    = res_hi;
                    lo_d    = res_lo;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: doc/e_mdu.md
# e_mdu

Multi-cycle multiply/divide unit for the Execute stage of the five-stage MIPS pipeline. It consumes the forwarded register-file operands (rs/rt read data) carried into E and owns the architectural HI/LO registers. It also exports a `busy` flag, which the hazard unit uses to stall the D stage on any MDU-class instruction.

## Interface
- `MUL_CYCLES`, default 5: cycles `busy` stays high for MULT/MULTU (and MADD-class ops); must be ≥1.
- `DIV_CYCLES`, default 10: cycles `busy` stays high for DIV/DIVU; must be ≥1.
- `clk`  in  1  system clock, all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  E-stage instruction is an MDU op and is valid this cycle.
- `mdu_op`  in  4  operation: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU; 11–15 reserved.
- `rs_val`  in  32  forwarded rs operand.
- `rt_val`  in  32  forwarded rt operand.
- `busy`  out  1  operation in flight.
- `hi`  out  32  architectural HI (MFHI source).
- `lo`  out  32  architectural LO (MFLO source).

## Operation
- The FSM has two states.
  - IDLE: accepts work.
  - RUN: a countdown `cnt` is running, with operands and op latched.
- Acceptance happens on a rising edge where `start`=1, state=IDLE and `mdu_op` is a valid op.
  - Ops 1–4 (and 7–10 when enabled) latch `rs_val`, `rt_val` and `mdu_op`, load `cnt` with the op's cycle count, and go to RUN.
  - MTHI/MTLO write `hi`←`rs_val` / `lo`←`rs_val` at that same edge; the state stays IDLE and `busy` is never raised.
  - NONE, reserved and disabled ops are no-ops.
- RUN: `cnt` decrements each edge. On the edge where `cnt` reaches 0, `hi`/`lo` are written and the state returns to IDLE.
- `start` while in RUN is ignored: no latch, no restart, no MTHI/MTLO effect. The hazard unit guarantees a stall, and the bench checks that the ignore holds.
- Arithmetic rules:
  - MULT: {hi,lo} = signed 32×32→64 product.
  - MULTU: {hi,lo} = unsigned 32×32→64 product.
  - DIV: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - DIVU: unsigned quotient and remainder.
  - Divide by zero: `hi`/`lo` are left unchanged, but `busy` still runs the full DIV_CYCLES.
  - MADD/MADDU: {hi,lo} += signed/unsigned product, mod 2^64.
  - MSUB/MSUBU: {hi,lo} −= product, mod 2^64.
  - These accumulate ops use the {hi,lo} value present at the completion edge.
- The result is computed from the latched operands only. Later changes on `rs_val`/`rt_val` have no effect.

## Timing
- Reset (`rst`=0, asynchronous): state=IDLE, `cnt`=0, `busy`=0, `hi`=0, `lo`=0, latched operands cleared. This holds mid-operation: the in-flight result is discarded.
- Accept at edge k: `busy`=1 from just after edge k through edge k+N, where N is MUL_CYCLES or DIV_CYCLES.
  - `busy` is exactly N cycles high.
  - New `hi`/`lo` appear just after edge k+N, coincident with `busy` falling.
- During RUN, `hi`/`lo` hold their pre-op values.
- Back-to-back ops: a new `start` is accepted at edge k+N+1 at the earliest. It is not accepted at the edge where `busy` falls, because the state is still RUN before that edge.
- MTHI/MTLO latency: 1 edge; the value is visible the next cycle.
- `busy` is a registered output; `hi`/`lo` are registered.

## Configuration
- `E_MDU_MADD_EN` defined:
  - ops 7–10 are accepted, use MUL_CYCLES latency, and accumulate into {hi,lo} as above.
- `E_MDU_MADD_EN` undefined:
  - ops 7–10 are treated as reserved no-ops: no `busy`, no HI/LO change.
  - No 64-bit add/sub datapath is synthesized.

## Test plan
- Reset:
  - Drive `rst`=0 mid-DIV (cnt=4), then release → `busy`=0, `hi`=`lo`=0 immediately, with no later write.
- MULT:
  - Stimulus: rs=0xFFFFFFFE (−2), rt=0x00000003, start=1.
  - Required: `busy` high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - MULTU with the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV:
  - rs=0xFFFFFFF9 (−7), rt=2 → after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
  - Any / 0 → hi/lo unchanged, `busy` still 10 cycles.
- Busy-ignore:
  - Start DIV, then pulse start with MTHI rs=0x1234 and MULT during RUN → both ignored; the final hi/lo equal the DIV result.
  - A later start at edge k+11 is accepted.
- MTHI/MTLO:
  - MTHI rs=0xDEADBEEF, then the next cycle MTLO rs=0x0BADF00D → hi/lo updated one edge each, `busy` never 1.
- MADD (with `E_MDU_MADD_EN`):
  - Stimulus: hi=0, lo=0xFFFFFFFF, then MADDU rs=1, rt=1.
  - Required: hi=1, lo=0 after 5 cycles.
  - Without the macro → hi/lo unchanged, `busy`=0.
